// File: rtl/coefficient_rf_readback.sv
// Dumps NUM_ROWS coefficient RF rows (306 bits each) as 39 bytes per row over a valid/ready port.
// First valid 3 cycles after the DUMP edge, 2-cycle gap between rows; bytes hold until the sink accepts.
module coefficient_rf_readback #(
  parameter int NUM_ROWS = 50
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         conf_sys_ctrl_reg_DUMP,
  input  logic         conf_sys_ctrl_reg_RESET,
  input  logic         conf_sys_ctrl_reg_INIT,
  input  logic         conf_sys_ctrl_reg_LOAD,
  output logic [5:0]   rb_a,
  output logic         rb_active,
  output logic         rb_web,
  output logic [305:0] rb_bweb,
  input  logic [127:0] coefficient_rf_part1_q,
  input  logic [127:0] coefficient_rf_part2_q,
  input  logic [49:0]  spin_polarity_q,
  output logic [7:0]   out_GPIO_data,
  output logic         out_GPIO_valid,
  input  logic         in_GPIO_ready,
  output logic         dump_done
);

  localparam logic [5:0] LP_LAST_ROW  = 6'(NUM_ROWS - 1);
  localparam logic [5:0] LP_LAST_BYTE = 6'd38;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [5:0]     r_row;
  logic [5:0]     w_row_nxt;
  logic [5:0]     r_byte_cnt;
  logic [5:0]     w_byte_cnt_nxt;
  logic [305:0]   r_sr;
  logic [305:0]   w_sr_nxt;
  logic           r_dump_done;
  logic           w_dump_done_nxt;
  logic           r_dump_q;
  logic           r_reset_q;
  logic           w_start;
  logic           w_abort;
  logic           w_hs;

  assign w_start = conf_sys_ctrl_reg_DUMP & ~r_dump_q;
  assign w_abort = conf_sys_ctrl_reg_RESET & ~r_reset_q;
  assign w_hs    = (r_state == S_SEND) & in_GPIO_ready;

  assign rb_web  = 1'b1;
  assign rb_bweb = {306{1'b1}};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row       <= 6'd0;
      r_byte_cnt  <= 6'd0;
      r_sr        <= '0;
      r_dump_done <= 1'b0;
      r_dump_q    <= 1'b0;
      r_reset_q   <= 1'b0;
    end else begin
      r_row       <= w_row_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_dump_done <= w_dump_done_nxt;
      r_dump_q    <= conf_sys_ctrl_reg_DUMP;
      r_reset_q   <= conf_sys_ctrl_reg_RESET;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_sr_nxt        = r_sr;
    w_dump_done_nxt = r_dump_done;

    case (r_state)
      S_IDLE: begin
        if (w_start && !conf_sys_ctrl_reg_INIT && !conf_sys_ctrl_reg_LOAD) begin
          w_row_nxt       = 6'd0;
          w_dump_done_nxt = 1'b0;
          w_state_nxt     = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // RF data for the address driven in READ is on the q buses now.
        w_sr_nxt       = {spin_polarity_q, coefficient_rf_part2_q, coefficient_rf_part1_q};
        w_byte_cnt_nxt = 6'd0;
        w_state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          if (r_byte_cnt == LP_LAST_BYTE) begin
            if (r_row == LP_LAST_ROW) begin
              w_dump_done_nxt = 1'b1;
              w_state_nxt     = S_DONE;
            end else begin
              w_row_nxt   = r_row + 6'd1;
              w_state_nxt = S_READ;
            end
          end else begin
            w_sr_nxt       = {r_sr[297:0], 8'h00};
            w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          end
        end
      end
      S_DONE: begin
        if (!conf_sys_ctrl_reg_DUMP) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_state_nxt     = S_IDLE;
      w_row_nxt       = 6'd0;
      w_byte_cnt_nxt  = 6'd0;
      w_dump_done_nxt = 1'b0;
    end
  end

  // Outputs decode registered state only, so an async reset clears them immediately.
  always_comb begin
    out_GPIO_valid = (r_state == S_SEND);
    out_GPIO_data  = 8'h00;
    if (r_state == S_SEND) begin
      if (r_byte_cnt == LP_LAST_BYTE) begin
        out_GPIO_data = {6'b0, r_sr[305:304]};
      end else begin
        out_GPIO_data = r_sr[305:298];
      end
    end
    rb_active = (r_state == S_READ) || (r_state == S_CAPTURE);
    rb_a      = rb_active ? r_row : 6'd0;
    dump_done = r_dump_done;
  end

endmodule

// File: tb/tb_coefficient_rf_readback.sv
// Bench for coefficient_rf_readback: RF model plus a byte scoreboard filled at each dump start
// and drained by a negedge monitor that also owns in_GPIO_ready.
module tb_coefficient_rf_readback;

  localparam int NR  = 50;
  localparam int BPR = 39;

  logic         i_clk;
  logic         i_rstn;
  logic         conf_sys_ctrl_reg_DUMP;
  logic         conf_sys_ctrl_reg_RESET;
  logic         conf_sys_ctrl_reg_INIT;
  logic         conf_sys_ctrl_reg_LOAD;
  logic [5:0]   rb_a;
  logic         rb_active;
  logic         rb_web;
  logic [305:0] rb_bweb;
  logic [127:0] coefficient_rf_part1_q;
  logic [127:0] coefficient_rf_part2_q;
  logic [49:0]  spin_polarity_q;
  logic [7:0]   out_GPIO_data;
  logic         out_GPIO_valid;
  logic         in_GPIO_ready;
  logic         dump_done;

  logic [127:0] p1_mem [64];
  logic [127:0] p2_mem [64];
  logic [49:0]  sp_mem [64];

  logic [7:0]   sb_q [$];
  int           n_tests;
  int           n_fail;
  int           hs_count;
  int           ready_mode;
  bit           skip_stab;

  coefficient_rf_readback #(.NUM_ROWS(NR)) dut (
    .i_clk                  (i_clk),
    .i_rstn                 (i_rstn),
    .conf_sys_ctrl_reg_DUMP (conf_sys_ctrl_reg_DUMP),
    .conf_sys_ctrl_reg_RESET(conf_sys_ctrl_reg_RESET),
    .conf_sys_ctrl_reg_INIT (conf_sys_ctrl_reg_INIT),
    .conf_sys_ctrl_reg_LOAD (conf_sys_ctrl_reg_LOAD),
    .rb_a                   (rb_a),
    .rb_active              (rb_active),
    .rb_web                 (rb_web),
    .rb_bweb                (rb_bweb),
    .coefficient_rf_part1_q (coefficient_rf_part1_q),
    .coefficient_rf_part2_q (coefficient_rf_part2_q),
    .spin_polarity_q        (spin_polarity_q),
    .out_GPIO_data          (out_GPIO_data),
    .out_GPIO_valid         (out_GPIO_valid),
    .in_GPIO_ready          (in_GPIO_ready),
    .dump_done              (dump_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous RF with one-cycle read latency.
  always @(posedge i_clk) begin
    coefficient_rf_part1_q <= p1_mem[rb_a];
    coefficient_rf_part2_q <= p2_mem[rb_a];
    spin_polarity_q        <= sp_mem[rb_a];
  end

  function automatic logic [7:0] exp_byte(int r, int k);
    logic [305:0] v;
    v = {sp_mem[r], p2_mem[r], p1_mem[r]};
    if (k < 38) return v[305 - 8*k -: 8];
    return {6'b0, v[1:0]};
  endfunction

  task automatic push_dump();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < BPR; k++)
        sb_q.push_back(exp_byte(r, k));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  initial begin : monitor
    logic       pv;
    logic       phs;
    logic [7:0] pd;
    logic [7:0] e;
    pv  = 1'b0;
    phs = 1'b0;
    pd  = 8'h00;
    forever begin
      @(negedge i_clk);
      if (pv && !phs && !skip_stab) begin
        n_tests++;
        if (out_GPIO_valid !== 1'b1 || out_GPIO_data !== pd) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_GPIO_valid, out_GPIO_data, pd);
        end
      end
      case (ready_mode)
        0:       in_GPIO_ready = 1'b0;
        1:       in_GPIO_ready = 1'b1;
        default: in_GPIO_ready = 1'($urandom_range(0, 1));
      endcase
      phs = out_GPIO_valid && in_GPIO_ready;
      pv  = out_GPIO_valid;
      pd  = out_GPIO_data;
      if (phs) begin
        hs_count++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL byte_unexpected: got %h, required no byte", out_GPIO_data);
        end else begin
          e = sb_q.pop_front();
          if (out_GPIO_data !== e) begin
            n_fail++;
            $display("FAIL byte_data #%0d: got %h, required %h", hs_count, out_GPIO_data, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({out_GPIO_valid, out_GPIO_data, rb_active, rb_a, dump_done} !== 17'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: valid=%b data=%h act=%b a=%0d done=%b, required all 0",
               out_GPIO_valid, out_GPIO_data, rb_active, rb_a, dump_done);
    end
    i_rstn = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (rb_web !== 1'b1 || rb_bweb !== {306{1'b1}}) begin
      n_fail++;
      $display("FAIL rst_web: web=%b bweb_all_ones=%b, required 1/1", rb_web, (rb_bweb === {306{1'b1}}));
    end
    n_tests++;
    if (out_GPIO_valid !== 1'b0 || rb_active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: valid=%b act=%b, required 0/0", out_GPIO_valid, rb_active);
    end
  endtask

  task automatic test_full_dump();
    int base, row_exp, bad_a, gap, ngaps, bad_gap;
    bit prev_act, chk38;
    ready_mode = 1;
    push_dump();
    base = hs_count;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    tick();
    n_tests++;
    if (rb_active !== 1'b1 || rb_a !== 6'd0 || out_GPIO_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_read: act=%b a=%0d valid=%b, required 1/0/0", rb_active, rb_a, out_GPIO_valid);
    end
    tick();
    n_tests++;
    if (rb_active !== 1'b1 || out_GPIO_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_capture: act=%b valid=%b, required 1/0", rb_active, out_GPIO_valid);
    end
    tick();
    n_tests++;
    if (out_GPIO_valid !== 1'b1 || out_GPIO_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL lat_first_byte: valid=%b data=%h, required 1/c0", out_GPIO_valid, out_GPIO_data);
    end
    row_exp = 1; bad_a = 0; gap = 0; ngaps = 0; bad_gap = 0;
    prev_act = 1'b0; chk38 = 1'b0;
    for (int c = 0; c < 4000 && dump_done !== 1'b1; c++) begin
      tick();
      if (!chk38 && hs_count - base == 38) begin
        chk38 = 1'b1;
        n_tests++;
        if (out_GPIO_data !== 8'h01) begin
          n_fail++;
          $display("FAIL row0_byte38: got %h, required 01", out_GPIO_data);
        end
      end
      if (rb_active && !prev_act) begin
        if (rb_a !== 6'(row_exp)) bad_a++;
        row_exp++;
      end
      prev_act = rb_active;
      if (!out_GPIO_valid) gap++;
      else if (gap != 0) begin
        ngaps++;
        if (gap != 2) bad_gap++;
        gap = 0;
      end
    end
    n_tests++;
    if (dump_done !== 1'b1 || out_GPIO_valid !== 1'b0 || hs_count - base != NR * BPR) begin
      n_fail++;
      $display("FAIL full_done: done=%b valid=%b handshakes=%0d, required 1/0/%0d",
               dump_done, out_GPIO_valid, hs_count - base, NR * BPR);
    end
    n_tests++;
    if (row_exp != NR || bad_a != 0) begin
      n_fail++;
      $display("FAIL full_rb_a: rows=%0d bad=%0d, required %0d/0", row_exp, bad_a, NR);
    end
    n_tests++;
    if (ngaps != NR - 1 || bad_gap != 0) begin
      n_fail++;
      $display("FAIL full_gaps: gaps=%0d bad=%0d, required %0d/0", ngaps, bad_gap, NR - 1);
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_leftover: %0d bytes pending, required 0", sb_q.size());
    end
    repeat (3) tick();
    n_tests++;
    if (dump_done !== 1'b1 || out_GPIO_valid !== 1'b0 || rb_active !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: done=%b valid=%b act=%b, required 1/0/0", dump_done, out_GPIO_valid, rb_active);
    end
    conf_sys_ctrl_reg_DUMP = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (dump_done !== 1'b1 || out_GPIO_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_after_idle: done=%b valid=%b, required 1/0", dump_done, out_GPIO_valid);
    end
  endtask

  task automatic test_blocked_start();
    int anyv, anya;
    ready_mode = 1;
    anyv = 0; anya = 0;
    conf_sys_ctrl_reg_INIT = 1'b1;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    repeat (8) begin
      tick();
      if (out_GPIO_valid) anyv++;
      if (rb_active) anya++;
    end
    conf_sys_ctrl_reg_INIT = 1'b0;
    repeat (4) begin
      tick();
      if (out_GPIO_valid) anyv++;
      if (rb_active) anya++;
    end
    n_tests++;
    if (anyv != 0 || anya != 0 || dump_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_block: valid_cycles=%0d act_cycles=%0d done=%b, required 0/0/1", anyv, anya, dump_done);
    end
    conf_sys_ctrl_reg_DUMP = 1'b0;
    tick();
    anyv = 0; anya = 0;
    conf_sys_ctrl_reg_LOAD = 1'b1;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    repeat (8) begin
      tick();
      if (out_GPIO_valid) anyv++;
      if (rb_active) anya++;
    end
    n_tests++;
    if (anyv != 0 || anya != 0) begin
      n_fail++;
      $display("FAIL load_block: valid_cycles=%0d act_cycles=%0d, required 0/0", anyv, anya);
    end
    conf_sys_ctrl_reg_LOAD = 1'b0;
    conf_sys_ctrl_reg_DUMP = 1'b0;
    tick();
  endtask

  task automatic test_random_ready();
    int base;
    ready_mode = 2;
    push_dump();
    base = hs_count;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    tick();
    n_tests++;
    if (dump_done !== 1'b0 || rb_active !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clears_done: done=%b act=%b, required 0/1", dump_done, rb_active);
    end
    for (int c = 0; c < 2000 && hs_count - base < 60; c++) tick();
    conf_sys_ctrl_reg_DUMP = 1'b0;
    tick();
    conf_sys_ctrl_reg_DUMP = 1'b1;
    for (int c = 0; c < 9000 && dump_done !== 1'b1; c++) tick();
    n_tests++;
    if (dump_done !== 1'b1 || hs_count - base != NR * BPR || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_dump: done=%b handshakes=%0d pending=%0d, required 1/%0d/0",
               dump_done, hs_count - base, sb_q.size(), NR * BPR);
    end
    conf_sys_ctrl_reg_DUMP = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    int base;
    logic [7:0] e;
    ready_mode = 1;
    push_dump();
    base = hs_count;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    tick();
    for (int c = 0; c < 1000 && hs_count - base < 10 * BPR + 20; c++) tick();
    e = exp_byte(10, 20);
    n_tests++;
    if (out_GPIO_valid !== 1'b1 || out_GPIO_data !== e) begin
      n_fail++;
      $display("FAIL abort_pre: valid=%b data=%h, required 1/%h", out_GPIO_valid, out_GPIO_data, e);
    end
    skip_stab = 1'b1;
    conf_sys_ctrl_reg_RESET = 1'b1;
    conf_sys_ctrl_reg_DUMP  = 1'b0;
    tick();
    n_tests++;
    if ({out_GPIO_valid, dump_done, rb_active, rb_a} !== 9'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: valid=%b done=%b act=%b a=%0d, required all 0",
               out_GPIO_valid, dump_done, rb_active, rb_a);
    end
    sb_q.delete();
    conf_sys_ctrl_reg_RESET = 1'b0;
    repeat (2) tick();
    skip_stab = 1'b0;
    push_dump();
    base = hs_count;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    tick();
    n_tests++;
    if (rb_active !== 1'b1 || rb_a !== 6'd0) begin
      n_fail++;
      $display("FAIL restart_row0: act=%b a=%0d, required 1/0", rb_active, rb_a);
    end
    repeat (2) tick();
    e = exp_byte(0, 0);
    n_tests++;
    if (out_GPIO_valid !== 1'b1 || out_GPIO_data !== e) begin
      n_fail++;
      $display("FAIL restart_byte0: valid=%b data=%h, required 1/%h", out_GPIO_valid, out_GPIO_data, e);
    end
    for (int c = 0; c < 4000 && dump_done !== 1'b1; c++) tick();
    n_tests++;
    if (dump_done !== 1'b1 || hs_count - base != NR * BPR || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_dump: done=%b handshakes=%0d pending=%0d, required 1/%0d/0",
               dump_done, hs_count - base, sb_q.size(), NR * BPR);
    end
    conf_sys_ctrl_reg_DUMP = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    int base;
    ready_mode = 1;
    push_dump();
    base = hs_count;
    conf_sys_ctrl_reg_DUMP = 1'b1;
    tick();
    for (int c = 0; c < 1000 && hs_count - base < 100; c++) tick();
    skip_stab = 1'b1;
    i_rstn = 1'b0;
    #1;
    n_tests++;
    if ({out_GPIO_valid, out_GPIO_data, rb_active, rb_a, dump_done} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_rst: valid=%b data=%h act=%b a=%0d done=%b, required all 0",
               out_GPIO_valid, out_GPIO_data, rb_active, rb_a, dump_done);
    end
    sb_q.delete();
    conf_sys_ctrl_reg_DUMP = 1'b0;
    repeat (2) tick();
    i_rstn = 1'b1;
    repeat (2) tick();
    skip_stab = 1'b0;
    n_tests++;
    if (out_GPIO_valid !== 1'b0 || rb_active !== 1'b0 || dump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle: valid=%b act=%b done=%b, required 0/0/0", out_GPIO_valid, rb_active, dump_done);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; hs_count = 0;
    ready_mode = 1; skip_stab = 1'b0;
    i_rstn = 1'b0;
    in_GPIO_ready = 1'b0;
    conf_sys_ctrl_reg_DUMP  = 1'b0;
    conf_sys_ctrl_reg_RESET = 1'b0;
    conf_sys_ctrl_reg_INIT  = 1'b0;
    conf_sys_ctrl_reg_LOAD  = 1'b0;
    for (int r = 0; r < 64; r++) begin
      p1_mem[r] = {$urandom, $urandom, $urandom, $urandom};
      p2_mem[r] = {$urandom, $urandom, $urandom, $urandom};
      sp_mem[r] = 50'({$urandom, $urandom});
    end
    p1_mem[0] = 128'h1;
    p2_mem[0] = 128'h0;
    sp_mem[0] = 50'h3_0000_0000_0000;

    test_reset();
    test_full_dump();
    test_blocked_start();
    test_random_ready();
    test_abort();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
